// File: rtl/multi_pass_shift_seq_pkg.sv
// Shared types and constants for the multi-pass shift sequencer.
package multi_pass_shift_seq_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam int   DATA_W   = 8;
    localparam int   MAX_STEP = 7;
    localparam logic MODE_SHL = 1'b0;
    localparam logic MODE_ROL = 1'b1;

endpackage

// File: rtl/multi_pass_shift_seq_if.sv
// Request/result handshake bundle between a requester and the shift sequencer.
interface multi_pass_shift_seq_if #(
    parameter int AMT_W = 5
);
    logic             in_valid;
    logic             in_ready;
    logic [7:0]       in_data;
    logic [AMT_W-1:0] in_amt;
    logic             in_rot;
    logic             out_valid;
    logic             out_ready;
    logic [7:0]       out_data;
    logic [1:0]       out_passes;

    modport master (
        output in_valid, in_data, in_amt, in_rot, out_ready,
        input  in_ready, out_valid, out_data, out_passes
    );

    modport slave (
        input  in_valid, in_data, in_amt, in_rot, out_ready,
        output in_ready, out_valid, out_data, out_passes
    );
endinterface

// File: rtl/multi_pass_shift_seq_leftshift.sv
// Combinational 8-bit shifter: logical left shift (c=0) or rotate left (c=1) by s.
module leftshift (
    input  logic [7:0] d,
    input  logic [2:0] s,
    input  logic       c,
    output logic [7:0] out
);
    logic [15:0] dbl;

    // Upper byte of the doubled word shifted left is the rotated byte.
    assign dbl = {d, d} << s;
    assign out = c ? dbl[15:8] : (d << s);
endmodule

// File: rtl/multi_pass_shift_seq.sv
// Splits a wide shift/rotate request into passes of at most MAX_STEP through leftshift.
module multi_pass_shift_seq
    import multi_pass_shift_seq_pkg::*;
#(
    parameter int AMT_W    = 5,
    parameter int MAX_STEP = multi_pass_shift_seq_pkg::MAX_STEP
) (
    input  logic                   clk,
    input  logic                   rst,
    multi_pass_shift_seq_if.slave  bus
);
    state_t            state_q, state_d;
    logic [DATA_W-1:0] work_q, work_d;
    logic [3:0]        rem_q, rem_d;
    logic [1:0]        passes_q, passes_d;
    logic              mode_q, mode_d;

    logic [2:0]        step;
    logic [3:0]        eff;
    logic [DATA_W-1:0] shifted;

    // Remaining count never exceeds 8, so step fits the shifter's 3-bit amount.
    assign step = (rem_q > 4'(MAX_STEP)) ? 3'(MAX_STEP) : rem_q[2:0];

    leftshift u_shift (
        .d   (work_q),
        .s   (step),
        .c   (mode_q),
        .out (shifted)
    );

    always_comb begin
        eff = 4'd0;
        if (bus.in_rot == MODE_ROL) begin
            eff = {1'b0, bus.in_amt[2:0]};
        end else if (bus.in_amt >= AMT_W'(8)) begin
            eff = 4'd8;
        end else begin
            eff = bus.in_amt[3:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            work_q   <= '0;
            rem_q    <= '0;
            passes_q <= '0;
            mode_q   <= MODE_SHL;
        end else begin
            state_q  <= state_d;
            work_q   <= work_d;
            rem_q    <= rem_d;
            passes_q <= passes_d;
            mode_q   <= mode_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        work_d   = work_q;
        rem_d    = rem_q;
        passes_d = passes_q;
        mode_d   = mode_q;
        unique case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    work_d   = bus.in_data;
                    mode_d   = bus.in_rot;
                    rem_d    = eff;
                    passes_d = 2'd0;
                    state_d  = (eff == 4'd0) ? DONE : SHIFT;
                end
            end
            SHIFT: begin
                work_d   = shifted;
                rem_d    = rem_q - {1'b0, step};
                passes_d = passes_q + 2'd1;
                if (rem_q == {1'b0, step}) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        bus.in_ready  = (state_q == IDLE);
        bus.out_valid = (state_q == DONE);
    end

    assign bus.out_data   = work_q;
    assign bus.out_passes = passes_q;
endmodule

// File: tb/tb_multi_pass_shift_seq.sv
// Directed bench for multi_pass_shift_seq: vector table plus backpressure and reset sequences.
module tb_multi_pass_shift_seq;
    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;

    multi_pass_shift_seq_if #(.AMT_W(5)) bus ();

    multi_pass_shift_seq #(.AMT_W(5)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic       rot;
        logic [7:0] data;
        logic [4:0] amt;
        logic [7:0] exp_data;
        logic [1:0] exp_passes;
    } vec_t;

    vec_t vecs[12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Drive one request at a negedge; returns edges from accept until out_valid is seen.
    task automatic issue(input logic rot, input logic [7:0] data, input logic [4:0] amt,
                         output int lat);
        @(negedge clk);
        chk("in_ready_idle", 32'(bus.in_ready), 32'd1);
        bus.in_valid = 1'b1;
        bus.in_rot   = rot;
        bus.in_data  = data;
        bus.in_amt   = amt;
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        lat = 0;
        while (!bus.out_valid && lat < 10) begin
            @(posedge clk);
            @(negedge clk);
            lat++;
        end
        if (!bus.out_valid) begin
            n_checks++;
            n_fail++;
            $display("FAIL timeout: out_valid never rose, expected within 3 edges");
        end
    endtask

    initial begin
        int lat;
        n_checks = 0;
        n_fail   = 0;
        vecs = '{
            '{1'b1, 8'h81, 5'd1,  8'h03, 2'd1},
            '{1'b0, 8'hFF, 5'd9,  8'h00, 2'd2},
            '{1'b1, 8'hA5, 5'd12, 8'h5A, 2'd1},
            '{1'b0, 8'h3C, 5'd0,  8'h3C, 2'd0},
            '{1'b0, 8'h01, 5'd3,  8'h08, 2'd1},
            '{1'b1, 8'h81, 5'd7,  8'hC0, 2'd1},
            '{1'b0, 8'h01, 5'd7,  8'h80, 2'd1},
            '{1'b0, 8'h01, 5'd8,  8'h00, 2'd2},
            '{1'b0, 8'hFF, 5'd31, 8'h00, 2'd2},
            '{1'b1, 8'h5A, 5'd8,  8'h5A, 2'd0},
            '{1'b1, 8'h12, 5'd19, 8'h90, 2'd1},
            '{1'b0, 8'h03, 5'd4,  8'h30, 2'd1}
        };

        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_rot    = 1'b0;
        bus.in_data   = 8'h00;
        bus.in_amt    = 5'd0;
        bus.out_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_out_data", 32'(bus.out_data), 32'h00);
        chk("rst_out_passes", 32'(bus.out_passes), 32'd0);
        rst = 1'b0;

        for (int i = 0; i < 12; i++) begin
            issue(vecs[i].rot, vecs[i].data, vecs[i].amt, lat);
            chk($sformatf("v%0d_data", i), 32'(bus.out_data), 32'(vecs[i].exp_data));
            chk($sformatf("v%0d_passes", i), 32'(bus.out_passes), 32'(vecs[i].exp_passes));
            chk($sformatf("v%0d_latency", i), 32'(lat), 32'(vecs[i].exp_passes));
            // out_ready is high, so the next edge completes the result handshake
            @(posedge clk);
            @(negedge clk);
            chk($sformatf("v%0d_release", i), 32'(bus.out_valid), 32'd0);
        end

        // Backpressure: first result held while a second request waits on in_valid
        bus.out_ready = 1'b0;
        issue(1'b0, 8'h01, 5'd3, lat);
        bus.in_valid = 1'b1;
        bus.in_rot   = 1'b0;
        bus.in_data  = 8'h02;
        bus.in_amt   = 5'd1;
        for (int k = 0; k < 3; k++) begin
            chk("bp_valid", 32'(bus.out_valid), 32'd1);
            chk("bp_data", 32'(bus.out_data), 32'h08);
            chk("bp_in_ready", 32'(bus.in_ready), 32'd0);
            @(posedge clk);
            @(negedge clk);
        end
        chk("bp_data_hold", 32'(bus.out_data), 32'h08);
        bus.out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("bp_idle_after_hs", 32'(bus.in_ready), 32'd1);
        chk("bp_no_overlap", 32'(bus.out_valid), 32'd0);
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        chk("bp_second_accepted", 32'(bus.in_ready), 32'd0);
        lat = 0;
        while (!bus.out_valid && lat < 10) begin
            @(posedge clk);
            @(negedge clk);
            lat++;
        end
        chk("bp_second_data", 32'(bus.out_data), 32'h04);
        chk("bp_second_passes", 32'(bus.out_passes), 32'd1);
        @(posedge clk);
        @(negedge clk);

        // Reset during SHIFT discards the request
        bus.in_valid = 1'b1;
        bus.in_rot   = 1'b0;
        bus.in_data  = 8'hFF;
        bus.in_amt   = 5'd8;
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        chk("mr_in_shift", 32'(bus.in_ready), 32'd0);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("mr_out_valid", 32'(bus.out_valid), 32'd0);
        chk("mr_in_ready", 32'(bus.in_ready), 32'd1);
        chk("mr_out_data", 32'(bus.out_data), 32'h00);
        for (int k = 0; k < 5; k++) begin
            @(posedge clk);
            @(negedge clk);
            chk("mr_no_stale", 32'(bus.out_valid), 32'd0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/multi_pass_shift_seq.md
Name: multi_pass_shift_seq

Overview:
- Sequencing stage directly upstream of the team's combinational 8-bit shifter `leftshift` (ports d, s, c, out). It owns that shifter as its datapath.
- Accepts a byte, a shift amount wider than 3 bits and a mode bit over a valid/ready handshake.
- Splits the amount into passes of at most 7 positions, runs each pass through `leftshift` on successive clocks, and returns the result over a valid/ready handshake.
- Mode 0 = logical left shift (zero fill); mode 1 = rotate left.

Parameters:
- AMT_W, 5, width of the requested shift amount; must be at least 4.
- MAX_STEP, 7, largest per-pass amount; fixed by the 3-bit s input of `leftshift`.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  request valid.
- in_ready  out  1  block can accept a request.
- in_data  in  8  operand byte.
- in_amt  in  AMT_W  requested shift amount.
- in_rot  in  1  0 = logical shift left, 1 = rotate left; drives c of `leftshift`.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- out_data  out  8  shifted or rotated byte.
- out_passes  out  2  number of shifter passes used (0..2).

Behaviour:
- Clock and reset: one clock (clk); reset (rst) is synchronous and active-high.
- Reset state: state IDLE; in_ready=1; out_valid=0; out_data=0x00; out_passes=0; internal remaining-count=0; internal mode=0.
- Reset mid-operation: the in-flight request is discarded with no output. The cycle after the reset edge, in_ready=1 and out_valid=0.
- FSM states: IDLE, SHIFT, DONE. in_ready=1 only in IDLE; out_valid=1 only in DONE.
- Accept: an edge with in_valid&&in_ready is the accept edge E0.
  - Latch in_data into the work register and latch in_rot.
  - Compute the effective amount eff:
    - rotate: eff = in_amt[2:0].
    - logical: eff = min(in_amt, 8). Any amount of 8 or more yields 0x00.
  - If eff==0, go to DONE with data unchanged and passes=0. Otherwise go to SHIFT with remaining=eff and passes=0.
- SHIFT, each edge:
  - step = min(remaining, 7).
  - work <= leftshift(work, step, mode).
  - remaining <= remaining − step; passes <= passes + 1.
  - When remaining − step == 0, go to DONE on the same edge.
- Latency: the number of passes is P = ceil(eff/7), so P ≤ 2.
  - out_valid rises on edge E_P (on E0 when P=0) and is visible in the following cycle.
  - No further shifter activity occurs after DONE is entered.
- DONE:
  - out_data and out_passes come directly from registers and are stable while out_valid=1.
  - On out_valid&&out_ready, return to IDLE. A new request can be accepted one edge later; there is no same-edge overlap.
- Backpressure: out_valid, out_data and out_passes hold indefinitely while out_ready=0. in_valid is ignored whenever in_ready=0.
- The shifter's s input is driven only from the step value. Its d input is the work register. Its out feeds the work register only in SHIFT.
- Only the registered result is observable; combinational shifter output never reaches a port.

Decomposition:
- Shared package:
  - state enum {IDLE, SHIFT, DONE}.
  - constant DATA_W=8.
  - constant MAX_STEP=7.
  - mode constants MODE_SHL=0, MODE_ROL=1.
- Sub-module: one instance of the existing `leftshift` as the datapath. No other sub-modules.
- Step/clamp logic stays in this block.

Test Plan:
- Rotate, in_data=0x81, in_amt=1 → out_data=0x03, out_passes=1, out_valid visible 1 cycle after accept.
- Logical, in_data=0xFF, in_amt=9 → eff clamps to 8, passes 7 then 1 → out_data=0x00, out_passes=2.
- Rotate, in_data=0xA5, in_amt=12 → eff=4 → out_data=0x5A, out_passes=1.
- Logical, in_data=0x3C, in_amt=0 → out_data=0x3C, out_passes=0, out_valid in the cycle after accept.
- Backpressure: logical 0x01, amt 3, out_ready=0 for 3 cycles while in_valid stays 1 with new data → out_data holds 0x08, in_ready=0 throughout, second request accepted only after the out handshake.
- rst asserted during SHIFT of logical 0xFF amt 8 → next cycle out_valid=0, in_ready=1, out_data=0x00; no stale result ever appears.
